// File: rtl/apb_pkg.sv
// Shared APB definitions: responder state encoding and the default bus
// geometry that the master and responder are built against.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_resp_state_t;

    localparam int APB_ADDR_W   = 8;
    localparam int APB_DATA_W   = 8;
    localparam int APB_DEPTH    = 256;
    localparam int APB_RO_BASE  = 240;
    localparam int APB_WAIT_CYC = 2;
    localparam int APB_WAIT_W   = 4;

endpackage

// File: rtl/apb_regfile.sv
// Unreset DEPTH x DATA_W storage with one synchronous write port and one
// synchronous, read-enabled read port.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH  = APB_DEPTH,
    parameter int DATA_W = APB_DATA_W,
    parameter int AW     = 8
) (
    input  logic              PCLK,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port and registered read port; rdata holds between reads.
    always_ff @(posedge PCLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/apb_wait_responder.sv
// APB completer with a register file, programmable wait states, PSLVERR on
// unmapped or read-only accesses, and abort on protocol violation.
module apb_wait_responder
    import apb_pkg::*;
#(
    parameter int ADDR_W   = APB_ADDR_W,
    parameter int DATA_W   = APB_DATA_W,
    parameter int DEPTH    = APB_DEPTH,
    parameter int RO_BASE  = APB_RO_BASE,
    parameter int WAIT_CYC = APB_WAIT_CYC
) (
    input  logic              PCLK,
    input  logic              PRST,
    input  logic              PSEL,
    input  logic              PEN,
    input  logic              PWR,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDAT,
    output logic              PRDY,
    output logic [DATA_W-1:0] PRDAT,
    output logic              PSLVERR
);

    localparam int RF_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_SETUP  = 2'(SETUP);
    localparam logic [1:0] ST_ACCESS = 2'(ACCESS);
    localparam logic [APB_WAIT_W-1:0] WAIT_INIT = APB_WAIT_W'(WAIT_CYC);

    // The registered state only ever holds IDLE or ACCESS: the setup cycle is
    // recognised from the bus itself so that PRDY can rise in the very next cycle.
    logic [1:0]            state_r, state_nxt_s, phase_s;
    logic [APB_WAIT_W-1:0] cnt_r, cnt_nxt_s;
    logic                  err_r, err_nxt_s, err_s;
    logic                  wr_r, wr_nxt_s;
    logic [RF_AW-1:0]      addr_r, addr_nxt_s;
    logic                  rd_valid_r, rd_valid_nxt_s;
    logic                  prdy_r, prdy_nxt_s;
    logic                  pslverr_r, pslverr_nxt_s;
    logic                  setup_s, re_s, we_s;
    logic [DATA_W-1:0]     rdata_s;

    assign setup_s = PSEL & ~PEN;
    assign err_s   = (32'(PADDR) >= 32'(DEPTH)) | (PWR & (32'(PADDR) >= 32'(RO_BASE)));

    // Current bus phase as seen by the responder.
    always_comb begin
        if (state_r == ST_ACCESS) begin
            phase_s = ST_ACCESS;
        end else if (setup_s) begin
            phase_s = ST_SETUP;
        end else begin
            phase_s = ST_IDLE;
        end
    end

    // Next-state, wait counter, latching and memory port control.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        err_nxt_s      = err_r;
        wr_nxt_s       = wr_r;
        addr_nxt_s     = addr_r;
        rd_valid_nxt_s = rd_valid_r;
        re_s           = 1'b0;
        we_s           = 1'b0;
        case (phase_s)
            ST_ACCESS: begin
                if (PSEL && PEN) begin
                    if (cnt_r != {APB_WAIT_W{1'b0}}) begin
                        cnt_nxt_s = cnt_r - {{(APB_WAIT_W-1){1'b0}}, 1'b1};
                    end else begin
                        we_s        = wr_r & ~err_r;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    // Master abandoned the transfer: drop it without a write.
                    state_nxt_s    = ST_IDLE;
                    cnt_nxt_s      = {APB_WAIT_W{1'b0}};
                    err_nxt_s      = 1'b0;
                    rd_valid_nxt_s = 1'b0;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_IDLE;
            end
            ST_IDLE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // A setup cycle (including one that aborts an access) starts a transfer.
        if (setup_s) begin
            state_nxt_s = ST_ACCESS;
            cnt_nxt_s   = WAIT_INIT;
            err_nxt_s   = err_s;
            wr_nxt_s    = PWR;
            addr_nxt_s  = PADDR[RF_AW-1:0];
            if (!PWR) begin
                re_s           = ~err_s;
                rd_valid_nxt_s = ~err_s;
            end else begin
                re_s           = 1'b0;
            end
        end else begin
            re_s = 1'b0;
        end
    end

    // Output flags are registered copies of the decode of the next state.
    always_comb begin
        prdy_nxt_s    = (state_nxt_s == ST_ACCESS) && (cnt_nxt_s == {APB_WAIT_W{1'b0}});
        pslverr_nxt_s = prdy_nxt_s & err_nxt_s;
    end

    // Responder state registers.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {APB_WAIT_W{1'b0}};
            err_r      <= 1'b0;
            wr_r       <= 1'b0;
            addr_r     <= {RF_AW{1'b0}};
            rd_valid_r <= 1'b0;
            prdy_r     <= 1'b0;
            pslverr_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            err_r      <= err_nxt_s;
            wr_r       <= wr_nxt_s;
            addr_r     <= addr_nxt_s;
            rd_valid_r <= rd_valid_nxt_s;
            prdy_r     <= prdy_nxt_s;
            pslverr_r  <= pslverr_nxt_s;
        end
    end

    apb_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RF_AW)
    ) u_regfile (
        .PCLK  (PCLK),
        .we    (we_s),
        .waddr (addr_r),
        .wdata (PWDAT),
        .re    (re_s),
        .raddr (PADDR[RF_AW-1:0]),
        .rdata (rdata_s)
    );

    // The regfile read register is unreset, so it is qualified here to give a
    // zero PRDAT after reset, abort or an erroneous read.
    assign PRDY    = prdy_r;
    assign PSLVERR = pslverr_r;
    assign PRDAT   = rd_valid_r ? rdata_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_apb_wait_responder.sv
// Directed bench for apb_wait_responder: three builds (default, zero-wait,
// DEPTH=128) each on its own bus, checked through an expectation queue.
module tb_apb_wait_responder;

    logic       PCLK = 1'b0;
    logic       PRST;
    logic       psel [3];
    logic       pen [3];
    logic       pwr [3];
    logic [7:0] paddr [3];
    logic [7:0] pwdat [3];
    logic [7:0] prdat [3];
    logic       prdy [3];
    logic       pslverr [3];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        int         waits;
        logic       err;
        int         rd_mode;
        logic [7:0] rd;
    } exp_t;

    exp_t sb[$];

    always #5 PCLK = ~PCLK;

    apb_wait_responder u_dut_w2 (
        .PCLK(PCLK), .PRST(PRST), .PSEL(psel[0]), .PEN(pen[0]), .PWR(pwr[0]),
        .PADDR(paddr[0]), .PWDAT(pwdat[0]), .PRDY(prdy[0]), .PRDAT(prdat[0]),
        .PSLVERR(pslverr[0])
    );

    apb_wait_responder #(.WAIT_CYC(0)) u_dut_w0 (
        .PCLK(PCLK), .PRST(PRST), .PSEL(psel[1]), .PEN(pen[1]), .PWR(pwr[1]),
        .PADDR(paddr[1]), .PWDAT(pwdat[1]), .PRDY(prdy[1]), .PRDAT(prdat[1]),
        .PSLVERR(pslverr[1])
    );

    apb_wait_responder #(.DEPTH(128), .RO_BASE(112)) u_dut_d128 (
        .PCLK(PCLK), .PRST(PRST), .PSEL(psel[2]), .PEN(pen[2]), .PWR(pwr[2]),
        .PADDR(paddr[2]), .PWDAT(pwdat[2]), .PRDY(prdy[2]), .PRDAT(prdat[2]),
        .PSLVERR(pslverr[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        n_cmp++;
        assert (obs !== bad) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected anything but %0h", tag, obs, bad);
        end
    endtask

    // rd_mode: 0 = PRDAT not checked, 1 = must equal exp_rd, 2 = must differ from exp_rd
    task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        input logic exp_err, input int exp_waits, input int rd_mode,
                        input logic [7:0] exp_rd, input string tag);
        exp_t e;
        exp_t got;
        int   k;
        e.tag = tag; e.waits = exp_waits; e.err = exp_err; e.rd_mode = rd_mode; e.rd = exp_rd;
        sb.push_back(e);
        @(posedge PCLK); #1;
        psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdat[d] = ~wd;
        @(posedge PCLK); #1;
        // Disturb address/direction and present the real write data in the access phase.
        pen[d] = 1'b1; pwdat[d] = wr ? wd : 8'hEE; paddr[d] = a ^ 8'h01; pwr[d] = ~wr;
        k = 0;
        while (k <= 20) begin
            @(negedge PCLK);
            if (prdy[d] === 1'b1) break;
            k++;
        end
        got = sb.pop_front();
        check({got.tag, "_wait"}, 32'(k), 32'(got.waits));
        check({got.tag, "_err"}, 32'(pslverr[d]), 32'(got.err));
        if (got.rd_mode == 1) check({got.tag, "_rdata"}, 32'(prdat[d]), 32'(got.rd));
        if (got.rd_mode == 2) check_ne({got.tag, "_rdata"}, 32'(prdat[d]), 32'(got.rd));
        @(posedge PCLK); #1;
        psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
        @(negedge PCLK);
        check({got.tag, "_pulse"}, 32'(prdy[d]), 32'd0);
    endtask

    initial begin
        int hits;
        PRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            psel[i] = 1'b0; pen[i] = 1'b0; pwr[i] = 1'b0; paddr[i] = 8'h00; pwdat[i] = 8'h00;
        end
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_prdy", 32'(prdy[0]), 32'd0);
        check("rst_prdat", 32'(prdat[0]), 32'd0);
        check("rst_pslverr", 32'(pslverr[0]), 32'd0);
        @(posedge PCLK); #1 PRST = 1'b1;

        // Basic write/read with two wait states and PRDAT hold across a write.
        xfer(0, 1'b1, 8'h20, 8'hA5, 1'b0, 2, 0, 8'h00, "wr20");
        xfer(0, 1'b0, 8'h20, 8'h00, 1'b0, 2, 1, 8'hA5, "rd20");
        xfer(0, 1'b1, 8'h21, 8'h66, 1'b0, 2, 1, 8'hA5, "wr21_hold");
        xfer(0, 1'b1, 8'h22, 8'h5C, 1'b0, 2, 0, 8'h00, "wr22");
        xfer(0, 1'b0, 8'h22, 8'h00, 1'b0, 2, 1, 8'h5C, "rd22");
        xfer(0, 1'b0, 8'h21, 8'h00, 1'b0, 2, 1, 8'h66, "rd21");

        // Reset in the second access cycle of a write of 0x5A to 0x10.
        @(posedge PCLK); #1;
        psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 8'h10; pwdat[0] = 8'h5A;
        @(posedge PCLK); #1 pen[0] = 1'b1;
        @(posedge PCLK); #1 PRST = 1'b0;
        #1;
        check("midrst_prdy", 32'(prdy[0]), 32'd0);
        check("midrst_prdat", 32'(prdat[0]), 32'd0);
        check("midrst_pslverr", 32'(pslverr[0]), 32'd0);
        psel[0] = 1'b0; pen[0] = 1'b0; pwr[0] = 1'b0;
        @(posedge PCLK); #1 PRST = 1'b1;
        xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, 2, 2, 8'h5A, "rd10_after_rst");
        xfer(0, 1'b0, 8'h20, 8'h00, 1'b0, 2, 1, 8'hA5, "rd20_after_rst");

        // Read-only region and its lower boundary.
        xfer(0, 1'b1, 8'hF5, 8'hFF, 1'b1, 2, 0, 8'h00, "wr_ro_f5");
        xfer(0, 1'b0, 8'hF5, 8'h00, 1'b0, 2, 2, 8'hFF, "rd_ro_f5");
        xfer(0, 1'b1, 8'hEF, 8'h12, 1'b0, 2, 0, 8'h00, "wr_ef");
        xfer(0, 1'b0, 8'hEF, 8'h00, 1'b0, 2, 1, 8'h12, "rd_ef");
        xfer(0, 1'b1, 8'hF0, 8'h34, 1'b1, 2, 0, 8'h00, "wr_ro_f0");

        // Abort: PSEL dropped in the second access cycle of a write of 0x77 to 0x30.
        xfer(0, 1'b1, 8'h30, 8'h11, 1'b0, 2, 0, 8'h00, "wr30");
        @(posedge PCLK); #1;
        psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 8'h30; pwdat[0] = 8'h77;
        @(posedge PCLK); #1 pen[0] = 1'b1;
        @(posedge PCLK); #1 psel[0] = 1'b0; pen[0] = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            if (prdy[0] !== 1'b0 || pslverr[0] !== 1'b0) hits++;
        end
        check("abort_no_prdy", 32'(hits), 32'd0);
        xfer(0, 1'b0, 8'h30, 8'h00, 1'b0, 2, 1, 8'h11, "rd30_after_abort");

        // Zero-wait build.
        xfer(1, 1'b1, 8'h01, 8'h3C, 1'b0, 0, 0, 8'h00, "zw_wr01");
        xfer(1, 1'b0, 8'h01, 8'h00, 1'b0, 0, 1, 8'h3C, "zw_rd01");

        // DEPTH=128 build: unmapped space and the read-only boundary.
        xfer(2, 1'b1, 8'h6F, 8'h9A, 1'b0, 2, 0, 8'h00, "d128_wr6f");
        xfer(2, 1'b0, 8'h6F, 8'h00, 1'b0, 2, 1, 8'h9A, "d128_rd6f");
        xfer(2, 1'b0, 8'h90, 8'h00, 1'b1, 2, 1, 8'h00, "d128_rd90");
        xfer(2, 1'b0, 8'h80, 8'h00, 1'b1, 2, 1, 8'h00, "d128_rd80");
        xfer(2, 1'b1, 8'h70, 8'h55, 1'b1, 2, 0, 8'h00, "d128_wr70");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_wait_responder.md
# apb_wait_responder

APB completer (responder) that terminates transfers driven by the team's APB master: a parameterised register file with programmable wait states, `PSLVERR` signalling for illegal accesses, and clean abort on protocol violation. It sits on the far end of the APB link and replaces the zero-wait slave wherever back-pressure or error paths must be exercised.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `DEPTH`, 256: implemented words; addresses ≥ `DEPTH` are unmapped.
- `RO_BASE`, 240: addresses in [`RO_BASE`, `DEPTH`) are read-only.
- `WAIT_CYC`, 2: wait states inserted per transfer (0..15).
- `PCLK` in 1: clock, rising edge.
- `PRST` in 1: reset. Asynchronous, active-low.
- `PSEL` in 1: select.
- `PEN` in 1: enable (access phase).
- `PWR` in 1: 1 = write, 0 = read.
- `PADDR` in `ADDR_W`: address.
- `PWDAT` in `DATA_W`: write data.
- `PRDY` out 1: transfer complete.
- `PRDAT` out `DATA_W`: read data, valid when `PRDY`=1 on a read.
- `PSLVERR` out 1: error, valid only while `PRDY`=1.

## Operation
- **FSM states:**
  - `IDLE`: no transfer.
  - `SETUP`: `PSEL`=1, `PEN`=0 seen this cycle.
  - `ACCESS`: `PSEL`=1, `PEN`=1.
- **Transitions:**
  - `IDLE`→`SETUP` on `PSEL & !PEN`.
  - `SETUP`→`ACCESS` unconditionally at the next edge.
  - `ACCESS`→`IDLE` at the completion edge (`PRDY & PSEL & PEN`).
  - `ACCESS`→`SETUP` instead if the next transfer's setup is presented without an idle cycle.
- **Protocol violation:** in `ACCESS` with `PRDY`=0, `PSEL`=0 or `PEN`=0 aborts the transfer.
  - FSM returns to `IDLE`, or to `SETUP` if `PSEL & !PEN`.
  - No memory write; outputs return to reset values.
- **Setup edge** (the edge leaving the `SETUP` cycle):
  - Load the wait counter with `WAIT_CYC`.
  - Register the error flag: `err = (PADDR ≥ DEPTH) | (PWR & PADDR ≥ RO_BASE)`.
  - Latch `PWR` and `PADDR`.
  - On a read, capture `PRDAT` ← `mem[PADDR]`, or 0 if erroneous.
- **Wait counting:** each `ACCESS` cycle with counter ≠ 0 decrements it.
- **Outputs:**
  - `PRDY` = (state==`ACCESS`) & (counter==0), decoded from registers only; no combinational path from inputs.
  - `PSLVERR` = `PRDY` & err.
- **Write commit:** on the completion edge, `mem[addr]` ← `PWDAT` only if not err. `PWDAT` is sampled at that edge, not at setup.
- **`PRDAT` hold:** holds its last read value through writes and idle cycles.
- **Address change mid-access:** `PADDR`/`PWR` changes during `ACCESS` are ignored; latched values are used.
- **Memory reset:** memory is not reset; contents are undefined until written.

## Timing
- **Reset:**
  - `PRDY`=0, `PRDAT`=0, `PSLVERR`=0.
  - FSM in `IDLE`, counter 0.
  - Reset asserted mid-transfer aborts it immediately; no write occurs.
- **Latency:** setup in cycle T0 → `PRDY`=1 in cycle T1+`WAIT_CYC`.
  - `WAIT_CYC`=0: zero-wait (`PRDY` in the first access cycle).
  - `WAIT_CYC`=2: `PRDY` in the third access cycle.
- **`PRDY` pulse:** high for exactly one cycle per transfer.
- **Minimum transfer:**
  - Back-to-back: 2+`WAIT_CYC` cycles.
  - With an idle cycle between transfers: 3+`WAIT_CYC` cycles.
- **Read-after-write:** write commit at completion edge N; a read whose setup cycle is N+1 or later returns the new data.

## Structure
- Package `apb_pkg`:
  - state enum `apb_resp_state_t` (`IDLE`/`SETUP`/`ACCESS`).
  - default width/depth constants shared with the master.
- Sub-module `apb_regfile`:
  - `DEPTH`×`DATA_W`.
  - one synchronous write port and one synchronous read port with read-enable.
  - no reset.
- Top level holds the FSM, wait counter, error decode and output registers.

## Test plan
- **Reset and idle:** assert `PRST`=0 mid-transfer (write 0x5A to 0x10, `WAIT_CYC`=2) → all outputs 0 immediately; later read of 0x10 does not return 0x5A unless previously written.
- **Write then read:** write 0xA5 to 0x20, then read 0x20 with `WAIT_CYC`=2 → `PRDY` in the 3rd access cycle each time; `PRDAT`=0xA5; `PSLVERR`=0.
- **Zero-wait:** build with `WAIT_CYC`=0; write 0x3C to 0x01 then read it back → `PRDY` in the first access cycle; `PRDAT`=0x3C.
- **Read-only region:** write 0xFF to 0xF5 → `PSLVERR`=1 with `PRDY`; a subsequent read of 0xF5 returns the prior content, unchanged. A read of 0xF5 itself gives `PSLVERR`=0.
- **Unmapped address:** build with `DEPTH`=128; read 0x90 → `PSLVERR`=1, `PRDAT`=0x00.
- **Abort:** drop `PSEL` during the 2nd access cycle of a write of 0x77 to 0x30 → `PRDY` never asserts; FSM back in `IDLE`; a later read of 0x30 shows the old value.
